// File: rtl/controller_sequencer_pkg.sv
// controller_sequencer_pkg: opcodes, T-state encoding and control-word layout
package controller_sequencer_pkg;
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;
  localparam int CW_W    = 12;
  localparam int CW_CP   = 11;
  localparam int CW_EP   = 10;
  localparam int CW_LM_N = 9;
  localparam int CW_CE_N = 8;
  localparam int CW_LI_N = 7;
  localparam int CW_EI_N = 6;
  localparam int CW_LA_N = 5;
  localparam int CW_EA   = 4;
  localparam int CW_SU   = 3;
  localparam int CW_EU   = 2;
  localparam int CW_LB_N = 1;
  localparam int CW_LO_N = 0;
  typedef logic [CW_W-1:0] cw_t;
  // Active-low positions are 1 so that XOR with an "asserted" mask yields pin levels
  localparam cw_t CW_IDLE = 12'h3E3;
  localparam cw_t CW_NONE = '0;
  function automatic cw_t cw_bit(input int pos);
    return cw_t'(1) << pos;
  endfunction
endpackage

// File: rtl/ring_counter.sv
// ring_counter: falling-edge one-hot T1..T6 ring with a halt latch that freezes at T4
module ring_counter
  import controller_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       halt_req,
  output logic [5:0] t_state,
  output logic       halted
);
  t_state_e state;
  // Rotate the ring each falling edge unless halting; the halt request latches at the end of T4
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state  <= T1;
      halted <= 1'b0;
    end else if (!halted) begin
      if (halt_req) halted <= 1'b1;
      else state <= t_state_e'({state[4:0], state[5]});
    end
  end
  assign t_state = state;
endmodule

// File: rtl/controller_sequencer.sv
// controller_sequencer: SAP-1 style control sequencer decoding ring state and opcode into control lines
module controller_sequencer
  import controller_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       ei_n,
  output logic       la_n,
  output logic       lb_n,
  output logic       lo_n,
  output logic       hlt,
  output logic [5:0] t_state
);
  logic halted, halt_req, is_alu, is_mem;
  cw_t  act, cw;
  ring_counter u_ring (
    .clk      (clk),
    .clr_n    (clr_n),
    .halt_req (halt_req),
    .t_state  (t_state),
    .halted   (halted)
  );
  assign halt_req = t_state == T4 && opcode == OP_HLT;
  assign is_alu   = opcode == OP_ADD || opcode == OP_SUB;
  assign is_mem   = is_alu || opcode == OP_LDA;
  // Asserted-signal mask per state; undefined opcodes and HLT fall through to nothing
  always_comb begin
    act = t_state == T1 ? cw_bit(CW_EP) | cw_bit(CW_LM_N) :
          t_state == T2 ? cw_bit(CW_CP) :
          t_state == T3 ? cw_bit(CW_CE_N) | cw_bit(CW_LI_N) :
          t_state == T4 ? (is_mem ? cw_bit(CW_EI_N) | cw_bit(CW_LM_N) :
                           opcode == OP_OUT ? cw_bit(CW_EA) | cw_bit(CW_LO_N) : CW_NONE) :
          t_state == T5 ? (opcode == OP_LDA ? cw_bit(CW_CE_N) | cw_bit(CW_LA_N) :
                           is_alu ? cw_bit(CW_CE_N) | cw_bit(CW_LB_N) |
                                    (opcode == OP_SUB ? cw_bit(CW_SU) : CW_NONE) : CW_NONE) :
          t_state == T6 ? (is_alu ? cw_bit(CW_EU) | cw_bit(CW_LA_N) |
                                    (opcode == OP_SUB ? cw_bit(CW_SU) : CW_NONE) : CW_NONE) :
          CW_NONE;
  end
  assign cw   = (clr_n && !halted) ? act ^ CW_IDLE : CW_IDLE;
  assign hlt  = clr_n && (halted || halt_req);
  assign cp   = cw[CW_CP];
  assign ep   = cw[CW_EP];
  assign lm_n = cw[CW_LM_N];
  assign ce_n = cw[CW_CE_N];
  assign li_n = cw[CW_LI_N];
  assign ei_n = cw[CW_EI_N];
  assign la_n = cw[CW_LA_N];
  assign ea   = cw[CW_EA];
  assign su   = cw[CW_SU];
  assign eu   = cw[CW_EU];
  assign lb_n = cw[CW_LB_N];
  assign lo_n = cw[CW_LO_N];
endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; the state register advances on the falling edge, and bus registers load on the rising edge.
REQ-002 The block SHALL have port clr_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port opcode, input, 4 bits: instruction-register upper nibble.
REQ-004 The block SHALL have outputs cp, ep, ea, su, eu, each 1 bit, active-high:
- cp: PC increment.
- ep: PC drives W bus.
- ea: accumulator drives W bus.
- su: subtract select.
- eu: ALU drives W bus.
REQ-005 The block SHALL have outputs lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n, each 1 bit, active-low:
- lm_n: MAR load.
- ce_n: RAM drives bus.
- li_n: IR load.
- ei_n: IR operand drives bus.
- la_n: accumulator load.
- lb_n: B-register load.
- lo_n: output-register load.
REQ-006 The block SHALL have output hlt, 1 bit: halted flag.
REQ-007 The block SHALL have output t_state, 6 bits: one-hot ring state T1..T6, with bit0 = T1.

Function
REQ-008 The ring counter SHALL be one-hot and SHALL advance on each falling clk edge: T1→T2→…→T6→T1.
REQ-009 Control outputs SHALL be combinational from t_state and opcode, so that they are stable at the next rising edge.
REQ-010 "Inactive" SHALL mean all active-high outputs 0 and all active-low outputs 1.
REQ-011 All control outputs not listed for a state SHALL be inactive in that state.
REQ-012 Fetch states SHALL be:
- T1: ep=1, lm_n=0.
- T2: cp=1.
- T3: ce_n=0, li_n=0.
REQ-013 Opcodes SHALL be LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF.
REQ-014 LDA SHALL drive T4 ei_n=0, lm_n=0; T5 ce_n=0, la_n=0; T6 nothing.
REQ-015 ADD SHALL drive T4 ei_n=0, lm_n=0; T5 ce_n=0, lb_n=0; T6 eu=1, la_n=0.
REQ-016 SUB SHALL be identical to ADD, plus su=1 in both T5 and T6.
REQ-017 OUT SHALL drive T4 ea=1, lo_n=0; T5 and T6 nothing.
REQ-018 Any undefined opcode SHALL execute as a NOP: T4–T6 inactive, and the ring continues.
REQ-019 HLT SHALL behave as follows:
- On reaching T4 with opcode=4'hF, hlt SHALL assert combinationally.
- A halt latch SHALL set on the falling edge that ends T4, so the ring freezes at T4.
- hlt SHALL stay 1 and all control outputs SHALL stay inactive until clr_n falls.
REQ-020 Opcode changes during T1–T3 SHALL NOT affect fetch outputs.
REQ-021 At most one W-bus driver (ep, ce_n low, ei_n low, ea, eu) SHALL be active in any state.

Reset
REQ-022 While clr_n=0, t_state SHALL be 6'b000001, the halt latch SHALL be 0, hlt SHALL be 0, and all control outputs SHALL be forced inactive regardless of state decode.
REQ-023 Assertion of clr_n SHALL take effect immediately, independent of clk, including mid-instruction and while halted.
REQ-024 After clr_n rises, T1 decode SHALL appear immediately (ep=1, lm_n=0), and the first advance SHALL occur on the next falling edge.

Structure
REQ-025 A shared package SHALL hold the opcode constants, T-state one-hot constants, and a 12-bit control-word bit-position map in the order cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n.
REQ-026 The ring counter with halt freeze SHALL be one sub-module, ring_counter; instruction decode SHALL reside in controller_sequencer.

Verification
REQ-027 Reset case: clr_n=0 with clk toggling → t_state=000001, hlt=0, all outputs inactive; after release, ep=1 and lm_n=0 immediately.
REQ-028 ADD case: opcode=4'h1 for 6 falling edges → T5 lb_n=0, ce_n=0; T6 eu=1, la_n=0; su=0 throughout; back to T1 on the 6th edge.
REQ-029 SUB case: opcode=4'h2 → identical to ADD, with su=1 exactly in T5 and T6.
REQ-030 OUT/NOP case: opcode=4'hE → T4 ea=1, lo_n=0; then opcode=4'h7 → T4–T6 fully inactive, and the ring wraps normally.
REQ-031 HLT case: opcode=4'hF → hlt=1 at T4; t_state holds 6'b001000 for 10 further cycles; clr_n pulse → T1 with hlt=0.
REQ-032 Mid-operation reset case: clr_n low during ADD T5 (lb_n=0) → lb_n=1 and t_state=000001 within the same time step, with no clk edge.
REQ-033 All cases: bus-contention check of REQ-021 asserted every cycle.
